cache_ctrl: RTL and testbench

//  Sequencing FSM for the direct-mapped, write-back, write-allocate cache built from cache_data and mem.

---
 rtl/cache_ctrl_pkg.sv | 25 ++
 rtl/cache_ctrl_perf_cnt.sv | 24 ++
 rtl/cache_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cache_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache sequencing controller: default widths and FSM state type.
package cache_ctrl_pkg;

    localparam int unsigned PA_WIDTH_DEF   = 32;
    localparam int unsigned WRD_WIDTH_DEF  = 32;
    localparam int unsigned MEM_WIDTH_DEF  = 128;
    localparam int unsigned INDEX_BITS_DEF = 6;
    localparam int unsigned OFF_BITS_DEF   = 4;
    localparam int unsigned CNT_WIDTH_DEF  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StEvict,
        StFill,
        StResp
    } state_t;

    // Tag width left over once index and block offset are taken out of the address.
    function automatic int unsigned tag_width(input int unsigned pa_w, input int unsigned idx_w,
                                              input int unsigned off_w);
        return pa_w - idx_w - off_w;
    endfunction

endpackage

// File: rtl/cache_ctrl_perf_cnt.sv
// Saturating event counter with enable and synchronous reset.
module cache_ctrl_perf_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q;

    // Count enabled events, holding at all-ones instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != {Width{1'b1}})) begin
            cnt_q <= cnt_q + Width'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_ctrl.sv
// Sequencing FSM for a direct-mapped, write-back, write-allocate cache: one CPU request at a
// time, lookup / dirty-victim write-back / refill / replay, plus hit, miss and write-back counters.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned PA_WIDTH   = PA_WIDTH_DEF,
    parameter int unsigned WRD_WIDTH  = WRD_WIDTH_DEF,
    parameter int unsigned MEM_WIDTH  = MEM_WIDTH_DEF,
    parameter int unsigned INDEX_BITS = INDEX_BITS_DEF,
    parameter int unsigned OFF_BITS   = OFF_BITS_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic                                     req_we,
    input  logic [PA_WIDTH-1:0]                      req_addr,
    input  logic [WRD_WIDTH-1:0]                     req_wdata,
    output logic                                     resp_valid,
    output logic [PA_WIDTH-1:0]                      dc_addr,
    output logic                                     dc_rd_en,
    output logic                                     dc_wr_en,
    output logic [WRD_WIDTH-1:0]                     dc_wdata,
    output logic                                     dc_fill_en,
    input  logic                                     dc_hit,
    input  logic                                     dc_vic_dirty,
    input  logic [PA_WIDTH-INDEX_BITS-OFF_BITS-1:0]  dc_vic_tag,
    output logic                                     mem_rd_en,
    output logic                                     mem_wr_en,
    output logic [PA_WIDTH-1:0]                      mem_addr,
    input  logic                                     mem_ack,
    output logic [CNT_WIDTH-1:0]                     hit_cnt,
    output logic [CNT_WIDTH-1:0]                     miss_cnt,
    output logic [CNT_WIDTH-1:0]                     wb_cnt
);

    localparam int unsigned TagW = tag_width(PA_WIDTH, INDEX_BITS, OFF_BITS);

    state_t state_q;
    logic   we_q;
    logic   first_q;    // first lookup of the current request; the post-fill replay is not counted
    logic   hit_en;
    logic   miss_en;
    logic   wb_en;

    logic [PA_WIDTH-1:0] fill_addr;
    logic [PA_WIDTH-1:0] evict_addr;

    assign fill_addr  = {dc_addr[PA_WIDTH-1 -: TagW], dc_addr[OFF_BITS +: INDEX_BITS],
                         {OFF_BITS{1'b0}}};
    assign evict_addr = {dc_vic_tag, dc_addr[OFF_BITS +: INDEX_BITS], {OFF_BITS{1'b0}}};

    // Request sequencing with registered handshake, strobe and mem address outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            dc_rd_en   <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            dc_addr    <= '0;
            dc_wdata   <= '0;
            we_q       <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        dc_addr   <= req_addr;
                        dc_wdata  <= req_wdata;
                        we_q      <= req_we;
                        first_q   <= 1'b1;
                        req_ready <= 1'b0;
                        dc_rd_en  <= 1'b1;
                        state_q   <= StLookup;
                    end
                end
                StLookup: begin
                    first_q  <= 1'b0;
                    dc_rd_en <= 1'b0;
                    if (dc_hit) begin
                        resp_valid <= 1'b1;
                        state_q    <= StResp;
                    end else if (dc_vic_dirty) begin
                        // mem_addr captures the victim tag while it is still on dc_vic_tag.
                        mem_wr_en <= 1'b1;
                        mem_addr  <= evict_addr;
                        state_q   <= StEvict;
                    end else begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= fill_addr;
                        state_q   <= StFill;
                    end
                end
                StEvict: begin
                    if (mem_ack) begin
                        mem_wr_en <= 1'b0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= fill_addr;
                        state_q   <= StFill;
                    end
                end
                StFill: begin
                    if (mem_ack) begin
                        mem_rd_en <= 1'b0;
                        dc_rd_en  <= 1'b1;
                        state_q   <= StLookup;
                    end
                end
                StResp: begin
                    req_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                default: begin
                    req_ready <= 1'b1;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    // Same-cycle cache writes and counter events; rst suppresses them so an abandoned fill
    // leaves the line untouched.
    always_comb begin
        dc_wr_en   = 1'b0;
        dc_fill_en = 1'b0;
        hit_en     = 1'b0;
        miss_en    = 1'b0;
        wb_en      = 1'b0;
        if (!rst) begin
            dc_wr_en   = (state_q == StLookup) && dc_hit && we_q;
            dc_fill_en = (state_q == StFill) && mem_ack;
            hit_en     = (state_q == StLookup) && dc_hit && first_q;
            miss_en    = (state_q == StLookup) && !dc_hit && first_q;
            wb_en      = (state_q == StEvict) && mem_ack;
        end
    end

    cache_ctrl_perf_cnt #(
        .Width (CNT_WIDTH)
    ) u_hit_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (hit_en),
        .cnt_o (hit_cnt)
    );

    cache_ctrl_perf_cnt #(
        .Width (CNT_WIDTH)
    ) u_miss_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (miss_en),
        .cnt_o (miss_cnt)
    );

    cache_ctrl_perf_cnt #(
        .Width (CNT_WIDTH)
    ) u_wb_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (wb_en),
        .cnt_o (wb_cnt)
    );

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: a small cache_data stand-in, a mem responder with programmable ack delay,
// and a request-level reference model of the cache contents and counters.
module tb_cache_ctrl;

    // Narrow counters so saturation is reached by ordinary traffic.
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] dc_addr, dc_wdata;
    logic        dc_rd_en, dc_wr_en, dc_fill_en;
    logic        dc_hit, dc_vic_dirty;
    logic [21:0] dc_vic_tag;
    logic        mem_rd_en, mem_wr_en, mem_ack;
    logic [31:0] mem_addr;
    logic [CW-1:0] hit_cnt, miss_cnt, wb_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_ctrl #(
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .dc_addr      (dc_addr),
        .dc_rd_en     (dc_rd_en),
        .dc_wr_en     (dc_wr_en),
        .dc_wdata     (dc_wdata),
        .dc_fill_en   (dc_fill_en),
        .dc_hit       (dc_hit),
        .dc_vic_dirty (dc_vic_dirty),
        .dc_vic_tag   (dc_vic_tag),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt),
        .wb_cnt       (wb_cnt)
    );

    // cache_data stand-in: tag array driven purely by the controller's strobes.
    bit        env_valid [64];
    bit        env_dirty [64];
    bit [21:0] env_tag   [64];
    logic [5:0] env_idx;

    assign env_idx      = dc_addr[9:4];
    assign dc_hit       = env_valid[env_idx] && (env_tag[env_idx] == dc_addr[31:10]);
    assign dc_vic_dirty = env_valid[env_idx] && env_dirty[env_idx];
    assign dc_vic_tag   = env_tag[env_idx];

    always @(posedge clk) begin
        if (dc_fill_en) begin
            env_valid[env_idx] <= 1'b1;
            env_tag[env_idx]   <= dc_addr[31:10];
            env_dirty[env_idx] <= 1'b0;
        end else if (dc_wr_en) begin
            env_dirty[env_idx] <= 1'b1;
        end
    end

    // Reference model: what each request must do, from the cache policy alone.
    bit        ref_valid [64];
    bit        ref_dirty [64];
    bit [21:0] ref_tag   [64];
    int        ref_hits, ref_misses, ref_wbs;
    bit        exp_hit, exp_evict;
    int        exp_lat;
    logic [31:0] exp_wb_addr, exp_rd_addr;

    task automatic model_req(input bit we, input logic [31:0] addr, input int d_wb,
                             input int d_rd);
        logic [5:0]  idx;
        logic [21:0] tg;
        idx         = addr[9:4];
        tg          = addr[31:10];
        exp_hit     = ref_valid[idx] && (ref_tag[idx] == tg);
        exp_evict   = !exp_hit && ref_valid[idx] && ref_dirty[idx];
        exp_wb_addr = {ref_tag[idx], idx, 4'h0};
        exp_rd_addr = {addr[31:4], 4'h0};
        exp_lat     = exp_hit ? 2 : (exp_evict ? 5 + d_wb + d_rd : 4 + d_rd);
        if (exp_hit) begin
            if (ref_hits < CMAX) ref_hits++;
        end else begin
            if (ref_misses < CMAX) ref_misses++;
            if (exp_evict && ref_wbs < CMAX) ref_wbs++;
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
            ref_dirty[idx] = 1'b0;
        end
        if (we) ref_dirty[idx] = 1'b1;
    endtask

    // Observations of one request.
    int          obs_lat, obs_resp_n, obs_wb_acks, obs_rd_acks, obs_rd_cyc;
    int          obs_fill_n, obs_fill_bad, obs_wr_n, obs_both;
    logic [31:0] obs_wb_addr, obs_rd_addr;

    // Issue one request and act as mem until resp_valid; acks come after d_wb / d_rd waits.
    task automatic run_req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           input int d_wb, input int d_rd, input bit hold, input bit stray);
        int k, wb_wait, rd_wait;
        bit done;
        model_req(we, addr, d_wb, d_rd);
        obs_lat = -1; obs_resp_n = 0; obs_wb_acks = 0; obs_rd_acks = 0; obs_rd_cyc = 0;
        obs_fill_n = 0; obs_fill_bad = 0; obs_wr_n = 0; obs_both = 0;
        obs_wb_addr = 'x; obs_rd_addr = 'x;
        wb_wait = 0; rd_wait = 0; done = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; mem_ack = 1'b0;
        @(posedge clk);
        k = 1;
        while (!done && k < 300) begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            mem_ack = 1'b0;
            if (mem_rd_en && mem_wr_en) obs_both++;
            if (mem_rd_en) obs_rd_cyc++;
            if (mem_wr_en) begin
                if (wb_wait == d_wb) begin
                    mem_ack = 1'b1; obs_wb_acks++; obs_wb_addr = mem_addr; wb_wait = 0;
                end else wb_wait++;
            end else if (mem_rd_en) begin
                if (rd_wait == d_rd) begin
                    mem_ack = 1'b1; obs_rd_acks++; obs_rd_addr = mem_addr; rd_wait = 0;
                end else rd_wait++;
            end else if (stray) begin
                mem_ack = 1'($urandom_range(0, 1));
            end
            #1;
            if (dc_fill_en) begin
                obs_fill_n++;
                if (!(mem_ack && mem_rd_en)) obs_fill_bad++;
            end
            if (dc_wr_en) obs_wr_n++;
            if (resp_valid) begin
                obs_resp_n++; obs_lat = k; done = 1'b1; req_valid = 1'b0;
            end
            if (!done) begin
                @(posedge clk);
                k++;
            end
        end
        if (!done) begin
            n_chk++; n_err++;
            $display("FAIL timeout: no resp_valid for addr %h within %0d cycles", addr, k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++; if (req_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_chk++; if (resp_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_resp: got %b want 0", resp_valid); end
        n_chk++; if ({dc_rd_en, dc_wr_en, dc_fill_en} !== 3'b000) begin n_err++;
            $display("FAIL reset_dc_en: got %b want 000", {dc_rd_en, dc_wr_en, dc_fill_en}); end
        n_chk++; if ({mem_rd_en, mem_wr_en} !== 2'b00) begin n_err++;
            $display("FAIL reset_mem_en: got %b want 00", {mem_rd_en, mem_wr_en}); end
        n_chk++; if (mem_addr !== 32'h0 || dc_addr !== 32'h0) begin n_err++;
            $display("FAIL reset_addr: got mem %h dc %h want 0", mem_addr, dc_addr); end
        n_chk++; if ({hit_cnt, miss_cnt, wb_cnt} !== '0) begin n_err++;
            $display("FAIL reset_cnt: got %0d %0d %0d want 0", hit_cnt, miss_cnt, wb_cnt); end
        ref_hits = 0; ref_misses = 0; ref_wbs = 0;
    endtask

    task automatic test_cold_read();
        run_req(1'b0, 32'h40, 32'h0, 0, 3, 1'b0, 1'b0);
        n_chk++; if (obs_rd_addr !== 32'h40 || obs_rd_acks != 1) begin n_err++;
            $display("FAIL cold_fill_addr: got %h (%0d acks) want 40", obs_rd_addr, obs_rd_acks); end
        n_chk++; if (obs_fill_n != 1 || obs_fill_bad != 0) begin n_err++;
            $display("FAIL cold_fill_en: got %0d (%0d off-ack) want 1", obs_fill_n, obs_fill_bad); end
        n_chk++; if (obs_lat != 7) begin n_err++;
            $display("FAIL cold_latency: got %0d want 7", obs_lat); end
        n_chk++; if (miss_cnt !== CW'(1) || hit_cnt !== CW'(0)) begin n_err++;
            $display("FAIL cold_cnt: got hit %0d miss %0d want 0 1", hit_cnt, miss_cnt); end
    endtask

    task automatic test_hit_repeat();
        run_req(1'b0, 32'h40, 32'h0, 0, 0, 1'b0, 1'b1);
        n_chk++; if (obs_rd_cyc != 0) begin n_err++;
            $display("FAIL hit_no_mem: got %0d mem_rd_en cycles want 0", obs_rd_cyc); end
        n_chk++; if (obs_lat != 2) begin n_err++;
            $display("FAIL hit_latency: got %0d want 2", obs_lat); end
        n_chk++; if (hit_cnt !== CW'(1)) begin n_err++;
            $display("FAIL hit_cnt: got %0d want 1", hit_cnt); end
    endtask

    task automatic test_write_evict();
        run_req(1'b1, 32'h44, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0);
        n_chk++; if (obs_wr_n != 1 || obs_lat != 2) begin n_err++;
            $display("FAIL wr_hit: got %0d writes lat %0d want 1 2", obs_wr_n, obs_lat); end
        n_chk++; if (dc_wdata !== 32'hDEADBEEF || dc_addr !== 32'h44) begin n_err++;
            $display("FAIL wr_latch: got %h @ %h want deadbeef @ 44", dc_wdata, dc_addr); end
        n_chk++; if (env_dirty[4] !== 1'b1) begin n_err++;
            $display("FAIL wr_dirty: got %b want 1", env_dirty[4]); end
        run_req(1'b0, 32'h1044, 32'h0, 2, 1, 1'b0, 1'b0);
        n_chk++; if (obs_wb_addr !== 32'h40 || obs_wb_acks != 1) begin n_err++;
            $display("FAIL evict_addr: got %h (%0d acks) want 40", obs_wb_addr, obs_wb_acks); end
        n_chk++; if (obs_rd_addr !== 32'h1040) begin n_err++;
            $display("FAIL evict_fill_addr: got %h want 1040", obs_rd_addr); end
        n_chk++; if (wb_cnt !== CW'(1) || obs_lat != 8) begin n_err++;
            $display("FAIL evict_wb: got wb %0d lat %0d want 1 8", wb_cnt, obs_lat); end
    endtask

    task automatic test_write_miss();
        run_req(1'b1, 32'h2080, 32'h12345678, 0, 0, 1'b0, 1'b0);
        n_chk++; if (obs_rd_addr !== 32'h2080 || obs_fill_n != 1) begin n_err++;
            $display("FAIL wmiss_fill: got %h fills %0d want 2080 1", obs_rd_addr, obs_fill_n); end
        n_chk++; if (obs_wr_n != 1 || env_dirty[8] !== 1'b1) begin n_err++;
            $display("FAIL wmiss_write: got %0d writes dirty %b want 1 1", obs_wr_n, env_dirty[8]); end
        n_chk++; if (miss_cnt !== CW'(3) || hit_cnt !== CW'(2)) begin n_err++;
            $display("FAIL wmiss_cnt: got hit %0d miss %0d want 2 3", hit_cnt, miss_cnt); end
        n_chk++; if (obs_lat != 4) begin n_err++;
            $display("FAIL wmiss_latency: got %0d want 4", obs_lat); end
    endtask

    task automatic test_hold_miss();
        int extra;
        run_req(1'b0, 32'h40C0, 32'h0, 0, 2, 1'b1, 1'b0);
        extra = 0;
        repeat (4) begin
            @(negedge clk); #1;
            if (resp_valid || !req_ready) extra++;
        end
        n_chk++; if (obs_resp_n != 1 || extra != 0) begin n_err++;
            $display("FAIL hold_single_resp: got %0d resp, %0d busy after, want 1 0",
                     obs_resp_n, extra); end
        n_chk++; if (miss_cnt !== CW'(4)) begin n_err++;
            $display("FAIL hold_cnt: got %0d want 4", miss_cnt); end
    endtask

    task automatic test_reset_mid_fill();
        int k;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3000; mem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!mem_rd_en && k < 10) begin @(negedge clk); k++; end
        n_chk++; if (mem_rd_en !== 1'b1) begin n_err++;
            $display("FAIL rstfill_reach: got mem_rd_en %b want 1", mem_rd_en); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1;
        #1;
        n_chk++; if (mem_rd_en !== 1'b0 || req_ready !== 1'b1) begin n_err++;
            $display("FAIL rstfill_idle: got rd %b ready %b want 0 1", mem_rd_en, req_ready); end
        n_chk++; if ({hit_cnt, miss_cnt, wb_cnt} !== '0) begin n_err++;
            $display("FAIL rstfill_cnt: got %0d %0d %0d want 0", hit_cnt, miss_cnt, wb_cnt); end
        n_chk++; if (dc_fill_en !== 1'b0) begin n_err++;
            $display("FAIL rstfill_late_ack: got dc_fill_en %b want 0", dc_fill_en); end
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        n_chk++; if (env_valid[0] !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstfill_line: got valid %b ready %b resp %b want 0 1 0",
                     env_valid[0], req_ready, resp_valid); end
        ref_hits = 0; ref_misses = 0; ref_wbs = 0;
    endtask

    task automatic test_saturate();
        int n;
        n = 0;
        while (ref_hits < CMAX && n < 40) begin
            run_req(1'b0, 32'h2080, 32'h0, 0, 0, 1'b0, 1'b1);
            n++;
        end
        n_chk++; if (hit_cnt !== CW'(CMAX)) begin n_err++;
            $display("FAIL sat_reach: got %0d want %0d", hit_cnt, CMAX); end
        run_req(1'b0, 32'h2080, 32'h0, 0, 0, 1'b0, 1'b0);
        n_chk++; if (hit_cnt !== CW'(CMAX) || obs_lat != 2) begin n_err++;
            $display("FAIL sat_hold: got %0d lat %0d want %0d 2", hit_cnt, obs_lat, CMAX); end
    endtask

    task automatic test_random();
        bit          we;
        logic [31:0] addr;
        int          d_wb, d_rd;
        for (int i = 0; i < 120; i++) begin
            we   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4)
                 | ($urandom_range(0, 3) << 2);
            d_wb = $urandom_range(0, 3);
            d_rd = $urandom_range(0, 3);
            run_req(we, addr, $urandom, d_wb, d_rd, 1'b0, 1'($urandom_range(0, 1)));
            n_chk++; if (obs_lat != exp_lat || obs_resp_n != 1) begin n_err++;
                $display("FAIL rnd_latency %h: got %0d (%0d resp) want %0d", addr, obs_lat,
                         obs_resp_n, exp_lat); end
            n_chk++; if (obs_wb_acks != int'(exp_evict)
                         || (exp_evict && obs_wb_addr !== exp_wb_addr)) begin n_err++;
                $display("FAIL rnd_writeback %h: got %0d @ %h want %0d @ %h", addr, obs_wb_acks,
                         obs_wb_addr, exp_evict, exp_wb_addr); end
            n_chk++; if (obs_rd_acks != int'(!exp_hit)
                         || (!exp_hit && obs_rd_addr !== exp_rd_addr)) begin n_err++;
                $display("FAIL rnd_refill %h: got %0d @ %h want %0d @ %h", addr, obs_rd_acks,
                         obs_rd_addr, !exp_hit, exp_rd_addr); end
            n_chk++; if (obs_fill_n != int'(!exp_hit) || obs_fill_bad != 0) begin n_err++;
                $display("FAIL rnd_fill_en %h: got %0d (%0d off-ack) want %0d", addr, obs_fill_n,
                         obs_fill_bad, !exp_hit); end
            n_chk++; if (obs_wr_n != int'(we) || obs_both != 0) begin n_err++;
                $display("FAIL rnd_strobes %h: got wr %0d both %0d want %0d 0", addr, obs_wr_n,
                         obs_both, we); end
            n_chk++; if (hit_cnt !== CW'(ref_hits) || miss_cnt !== CW'(ref_misses)
                         || wb_cnt !== CW'(ref_wbs)) begin n_err++;
                $display("FAIL rnd_counters: got %0d %0d %0d want %0d %0d %0d", hit_cnt,
                         miss_cnt, wb_cnt, ref_hits, ref_misses, ref_wbs); end
        end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_hit_repeat();
        test_write_evict();
        test_write_miss();
        test_hold_miss();
        test_reset_mid_fill();
        test_saturate();
        test_random();
        @(negedge clk);
        mem_ack = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
